// File: rtl/karatsuba_pp_gen.sv
// Sequential Karatsuba partial-product generator: three half-width products on one
// shared radix-2 shift-add multiplier, presented as three aligned addends g1+g2+g3 = a*b.
module karatsuba_pp_gen #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] g1,
    output logic [2*W-1:0] g2,
    output logic [2*W-1:0] g3,
    output logic           busy
);

    localparam int H  = W / 2;
    localparam int CW = $clog2(H + 2);
    localparam int AW = 2 * H + 2;

    typedef enum logic [2:0] {
        IDLE,
        MUL_HH,
        MUL_LL,
        MUL_SS,
        COMBINE,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [AW-1:0]  mcand_q, mcand_d;
    logic [H:0]     mplr_q, mplr_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*H-1:0] pp1_q, pp1_d, pp2_q, pp2_d;
    logic [2*W-1:0] g1_q, g1_d, g2_q, g2_d, g3_q, g3_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;

    logic [H:0]     sa, sb;
    logic [AW-1:0]  acc_step;
    logic [AW-1:0]  mid;
    logic           last_step;

    assign sa = {1'b0, a_q[W-1:H]} + {1'b0, a_q[H-1:0]};
    assign sb = {1'b0, b_q[W-1:H]} + {1'b0, b_q[H-1:0]};

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        pp1_d       = pp1_q;
        pp2_d       = pp2_q;
        g1_d        = g1_q;
        g2_d        = g2_q;
        g3_d        = g3_q;
        acc_step    = acc_q + (mplr_q[0] ? mcand_q : '0);
        last_step   = (cnt_q == CW'(H));
        // pp3 sits in the accumulator once MUL_SS completes; mid is never negative
        mid         = acc_q - {2'b00, pp1_q} - {2'b00, pp2_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    mcand_d = {{(H + 2){1'b0}}, a[W-1:H]};
                    mplr_d  = {1'b0, b[W-1:H]};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL_HH;
                end
            end
            MUL_HH, MUL_LL, MUL_SS: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_step) begin
                    cnt_d = '0;
                    if (state_q == MUL_HH) begin
                        pp1_d   = acc_step[2*H-1:0];
                        acc_d   = '0;
                        mcand_d = {{(H + 2){1'b0}}, a_q[H-1:0]};
                        mplr_d  = {1'b0, b_q[H-1:0]};
                        state_d = MUL_LL;
                    end else if (state_q == MUL_LL) begin
                        pp2_d   = acc_step[2*H-1:0];
                        acc_d   = '0;
                        mcand_d = {{(H + 1){1'b0}}, sa};
                        mplr_d  = sb;
                        state_d = MUL_SS;
                    end else begin
                        state_d = COMBINE;
                    end
                end
            end
            COMBINE: begin
                g1_d    = {pp1_q, {W{1'b0}}};
                g2_d    = {{(2 * W - AW){1'b0}}, mid} << H;
                g3_d    = {{W{1'b0}}, pp2_q};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            pp1_q       <= '0;
            pp2_q       <= '0;
            g1_q        <= '0;
            g2_q        <= '0;
            g3_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pp1_q       <= pp1_d;
            pp2_q       <= pp2_d;
            g1_q        <= g1_d;
            g2_q        <= g2_d;
            g3_q        <= g3_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign g1        = g1_q;
    assign g2        = g2_q;
    assign g3        = g3_q;

endmodule
